wb_j1_data_mem_responder: RTL
=============================

// Module: wb_j1_data_mem_responder
// PURPOSE
// Shared data-memory responder at the slave end of the J1 CPU data bus (cyc/we/adr/dat -> ack/dat).
// Serves NUM_CPU J1 cores with round-robin arbitration.
// Performs exactly one single-word access per grant and returns a one-cycle ack to the granted core only.
// Sits between the J1 core array and a word-addressed on-chip RAM. UART-range accesses never reach it.
// PARAMETERS
// NUM_CPU      4   number of requesting J1 cores (>=2)
// CPU_W        2   width of grant index, clog2(NUM_CPU)
// ADDR_W       10  word-address bits decoded; RAM depth 2**ADDR_W words
// DATA_W       32  data word width
// WAIT_STATES  1   extra wait cycles inserted before each memory operation (0..15)
// PORTS
// clk      in   1                 system clock, rising edge
// rst_n    in   1                 asynchronous active-low reset
// cyc_i    in   NUM_CPU           per-core request; held high until ack
// we_i     in   NUM_CPU           per-core write enable (1=store, 0=fetch)
// adr_i    in   NUM_CPU*DATA_W    per-core word address; core k at [k*DATA_W +: DATA_W]
// dat_i    in   NUM_CPU*DATA_W    per-core write data; same packing as adr_i
// ack_o    out  NUM_CPU           one-hot, one-cycle acknowledge to the granted core
// dat_o    out  DATA_W            read data, shared by all cores; valid only while some ack_o bit is high
// grant_o  out  CPU_W             index of the core being served
// busy_o   out  1                 high in BUSY and ACK
// BEHAVIOUR
// - Reset (async, rst_n=0): state=IDLE, ack_o=0, dat_o=0, grant_o=0, busy_o=0, rr_ptr=0, cnt=0.
//   RAM contents are not reset.
// - FSM IDLE -> BUSY -> ACK -> IDLE. All outputs are registered.
// - IDLE: at a clock edge with |cyc_i:
//   - grant = first k with cyc_i[k]=1, searching rr_ptr, rr_ptr+1, ... with wrap mod NUM_CPU;
//   - latch adr/dat/we of core k; set cnt=WAIT_STATES; go to BUSY.
//   - With no request, stay in IDLE.
// - BUSY: at each edge:
//   - If cyc_i[grant]=0: abort. Go to IDLE, perform no RAM write, assert no ack, leave rr_ptr unchanged.
//   - Else if cnt!=0: decrement cnt.
//   - Else perform the op and go to ACK:
//     - write: ram[adr[ADDR_W-1:0]] <= dat;
//     - read: dat_o <= ram[adr[ADDR_W-1:0]].
// - ACK: ack_o[grant]=1 for exactly one cycle; all other ack bits are 0.
//   - Next edge: go to IDLE, clear ack_o, set rr_ptr = grant+1 (wrapping to 0 after NUM_CPU-1).
//   - The ACK cycle does not arbitrate. The earliest new grant is at the edge ending the first IDLE cycle.
// - Latency: cyc_i rises in cycle 0 with the responder IDLE -> ack_o high in cycle 2+WAIT_STATES.
// - Out-of-range access: adr[DATA_W-1:ADDR_W] != 0.
//   - Write is discarded; read returns 0.
//   - Still acked with normal latency.
// - dat_o holds its last read value. Write accesses do not change dat_o.
// - The core may drop cyc_i combinationally in the ack cycle. Responder behaviour does not depend on cyc_i during ACK.
// - Changing adr/dat/we after grant has no effect; the latched values are used.
// - Simultaneous requests: exactly one is granted. Losers keep cyc_i high and are served in later rounds.
//   Starvation bound: NUM_CPU grants.
// - rst_n asserted mid-access: FSM returns to IDLE immediately, ack_o=0, and any pending write is dropped.
//   A write whose RAM edge already occurred stays committed.
// TESTING
// 1. Read latency, WAIT_STATES=1:
//    - core0 writes 0xDEADBEEF to adr 5 -> ack_o=4'b0001 in cycle 3.
//    - core0 then reads adr 5 -> ack in cycle 3 with dat_o=0xDEADBEEF.
// 2. Round robin, rr_ptr=0:
//    - cyc_i=4'b1010 held -> core1 acked first, then core3 acked.
//    - Re-assert 4'b1011 -> order 0, 1, 3.
// 3. Abort: core2 write to adr 7, drop cyc_i in BUSY -> no ack; a later read of adr 7 returns the prior value.
// 4. Out-of-range: core0 writes 0x1234 to adr 0x400 (ADDR_W=10) -> acked, ram[0] unchanged, read of 0x400 returns 0.
// 5. Async reset mid-BUSY: rst_n low between edges -> ack_o, busy_o and grant_o are 0 at once; FSM in IDLE after release.
// 6. WAIT_STATES=0 back-to-back: core1 reads with cyc_i re-raised right after each ack -> one ack every 3 cycles.

Source files
------------

// File: rtl/wb_j1_data_mem_responder.sv
// Shared single-port data RAM behind the J1 data bus: round-robin grant among NUM_CPU cores,
// one word access per grant, one-cycle ack back to the granted core.
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | waiting for any cyc_i; arbitrates and latches the winner
// S_BUSY | counting wait states, then performs the RAM read or write
// S_ACK  | ack_o pulses for the granted core; rr_ptr advances after
module wb_j1_data_mem_responder #(
  parameter int NUM_CPU     = 4,
  parameter int CPU_W       = 2,
  parameter int ADDR_W      = 10,
  parameter int DATA_W      = 32,
  parameter int WAIT_STATES = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_CPU-1:0]        cyc_i,
  input  logic [NUM_CPU-1:0]        we_i,
  input  logic [NUM_CPU*DATA_W-1:0] adr_i,
  input  logic [NUM_CPU*DATA_W-1:0] dat_i,
  output logic [NUM_CPU-1:0]        ack_o,
  output logic [DATA_W-1:0]         dat_o,
  output logic [CPU_W-1:0]          grant_o,
  output logic                      busy_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_ACK  = 2'd2
  } state_t;

  state_t              state;
  logic [CPU_W-1:0]    rr_ptr;
  logic [3:0]          cnt;
  logic [DATA_W-1:0]   adr_q;
  logic [DATA_W-1:0]   dat_q;
  logic                we_q;
  logic [CPU_W-1:0]    arb_pick;
  logic [CPU_W-1:0]    arb_idx;
  logic                in_range;
  logic                mem_we;

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // Scan offsets from the far end down so the closest requester to rr_ptr wins.
  always_comb begin
    arb_pick = rr_ptr;
    arb_idx  = '0;
    for (int i = NUM_CPU - 1; i >= 0; i--) begin
      arb_idx = CPU_W'((int'(rr_ptr) + i) % NUM_CPU);
      if (cyc_i[arb_idx]) arb_pick = arb_idx;
    end
  end

  assign in_range = (adr_q[DATA_W-1:ADDR_W] == '0);
  assign mem_we   = (state == S_BUSY) && cyc_i[grant_o] && (cnt == '0) && we_q && in_range;

  always_ff @(posedge clk) begin
    if (mem_we) mem[adr_q[ADDR_W-1:0]] <= dat_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      ack_o   <= '0;
      dat_o   <= '0;
      grant_o <= '0;
      busy_o  <= 1'b0;
      rr_ptr  <= '0;
      cnt     <= '0;
      adr_q   <= '0;
      dat_q   <= '0;
      we_q    <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (|cyc_i) begin
            grant_o <= arb_pick;
            adr_q   <= adr_i[arb_pick*DATA_W +: DATA_W];
            dat_q   <= dat_i[arb_pick*DATA_W +: DATA_W];
            we_q    <= we_i[arb_pick];
            cnt     <= 4'(WAIT_STATES);
            busy_o  <= 1'b1;
            state   <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (!cyc_i[grant_o]) begin
            // Core withdrew: no write, no ack, rr_ptr stays put.
            busy_o <= 1'b0;
            state  <= S_IDLE;
          end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            if (!we_q) dat_o <= in_range ? mem[adr_q[ADDR_W-1:0]] : '0;
            ack_o <= NUM_CPU'(1) << grant_o;
            state <= S_ACK;
          end
        end
        S_ACK: begin
          ack_o  <= '0;
          busy_o <= 1'b0;
          rr_ptr <= (grant_o == CPU_W'(NUM_CPU - 1)) ? '0 : grant_o + 1'b1;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
